// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared states, default widths and helpers for the RLE decompressor
package rle_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ZEROS = 3'd1;
    localparam state_t ST_ONES  = 3'd2;
    localparam state_t ST_EMIT  = 3'd3;
    localparam state_t ST_FLUSH = 3'd4;

    localparam int DEF_OUT_W  = 256;
    localparam int DEF_RUN_W  = 8;
    localparam int DEF_FILL_W = $clog2(DEF_OUT_W) + 1;

    function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/rle_stream_decompress_bit_writer.sv
// rtl/rle_stream_decompress_bit_writer.sv - writes n copies of one bit value MSB-first at offset fill
module rle_bit_writer #(
    parameter int OUT_W  = 256,
    parameter int FILL_W = 9,
    parameter int N_W    = 4
) (
    input  logic [OUT_W-1:0]  word_in,
    input  logic [FILL_W-1:0] fill,
    input  logic [N_W-1:0]    n,
    input  logic              value,
    output logic [OUT_W-1:0]  word_out
);

    logic [OUT_W-1:0] top_mask;
    logic [OUT_W-1:0] ins_mask;

    always_comb begin
        // n ones at the top of the word, then slid down past the already-filled bits
        top_mask = ~({OUT_W{1'b1}} >> n);
        ins_mask = top_mask >> fill;
        word_out = value ? (word_in | ins_mask) : (word_in & ~ins_mask);
    end

endmodule

// File: rtl/rle_stream_decompress.sv
// rtl/rle_stream_decompress.sv - run-length token to bit-word expander with output backpressure
module rle_stream_decompress
    import rle_pkg::*;
#(
    parameter int OUT_W        = DEF_OUT_W,
    parameter int RUN_W        = DEF_RUN_W,
    parameter int BITS_PER_CYC = 8,
    parameter int CNT_W        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RUN_W-1:0]         in_zero_run,
    input  logic [RUN_W-1:0]         in_one_run,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(OUT_W):0]   out_fill,
    output logic                     out_last,
    output logic [CNT_W-1:0]         bit_count,
    output logic [CNT_W-4:0]         byte_indx,
    output logic [2:0]               bit_indx,
    output logic                     busy
);

    localparam int FILL_W = $clog2(OUT_W) + 1;
    localparam int N_W    = $clog2(BITS_PER_CYC) + 1;

    state_t             state_q, state_d;
    state_t             resume_q, resume_d;
    state_t             next_run;
    logic [OUT_W-1:0]   word_q, word_d, word_wr;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [RUN_W-1:0]   zero_rem_q, zero_rem_d;
    logic [RUN_W-1:0]   one_rem_q, one_rem_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;
    logic [RUN_W-1:0]   rem_cur, rem_left;
    logic               wr_value;
    int unsigned        n_full;
    logic [N_W-1:0]     n;

    rle_bit_writer #(
        .OUT_W (OUT_W),
        .FILL_W(FILL_W),
        .N_W   (N_W)
    ) u_writer (
        .word_in (word_q),
        .fill    (fill_q),
        .n       (n),
        .value   (wr_value),
        .word_out(word_wr)
    );

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        word_d      = word_q;
        fill_d      = fill_q;
        zero_rem_d  = zero_rem_q;
        one_rem_d   = one_rem_q;
        last_d      = last_q;
        bit_count_d = bit_count_q;
        next_run    = ST_IDLE;

        wr_value = (state_q == ST_ONES);
        rem_cur  = wr_value ? one_rem_q : zero_rem_q;
        n_full   = min3(32'(rem_cur), 32'(BITS_PER_CYC), 32'(OUT_W) - 32'(fill_q));
        n        = N_W'(n_full);
        rem_left = rem_cur - RUN_W'(n);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    zero_rem_d = in_zero_run;
                    one_rem_d  = in_one_run;
                    last_d     = in_last;
                    if (in_zero_run != '0)     state_d = ST_ZEROS;
                    else if (in_one_run != '0) state_d = ST_ONES;
                    else if (in_last)          state_d = ST_FLUSH;
                end
            end
            ST_ZEROS, ST_ONES: begin
                word_d      = word_wr;
                fill_d      = fill_q + FILL_W'(n);
                bit_count_d = bit_count_q + CNT_W'(n);
                if (wr_value) one_rem_d  = rem_left;
                else          zero_rem_d = rem_left;

                if (rem_left != '0)                             next_run = state_q;
                else if (!wr_value && (one_rem_q != '0))        next_run = ST_ONES;
                else                                            next_run = last_q ? ST_FLUSH : ST_IDLE;

                // a full word parks the token; resume_q says where it picks up again
                if (fill_d == FILL_W'(OUT_W)) begin
                    state_d  = ST_EMIT;
                    resume_d = next_run;
                end else begin
                    state_d = next_run;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    word_d  = '0;
                    fill_d  = '0;
                    // an exactly-full final word already carried out_last
                    state_d = (resume_q == ST_FLUSH) ? ST_IDLE : resume_q;
                end
            end
            ST_FLUSH: begin
                if (out_ready) begin
                    word_d  = '0;
                    fill_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            resume_q    <= ST_IDLE;
            word_q      <= '0;
            fill_q      <= '0;
            zero_rem_q  <= '0;
            one_rem_q   <= '0;
            last_q      <= 1'b0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            word_q      <= word_d;
            fill_q      <= fill_d;
            zero_rem_q  <= zero_rem_d;
            one_rem_q   <= one_rem_d;
            last_q      <= last_d;
            bit_count_q <= bit_count_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        out_valid = (state_q == ST_EMIT) || (state_q == ST_FLUSH);
        out_data  = word_q;
        out_fill  = '0;
        out_last  = 1'b0;
        if (state_q == ST_EMIT) begin
            out_fill = FILL_W'(OUT_W);
            out_last = last_q && (zero_rem_q == '0) && (one_rem_q == '0);
        end else if (state_q == ST_FLUSH) begin
            out_fill = fill_q;
            out_last = 1'b1;
        end
        bit_count = bit_count_q;
        byte_indx = bit_count_q[CNT_W-1:3];
        bit_indx  = bit_count_q[2:0];
    end

endmodule

// File: tb/tb_rle_stream_decompress.sv
// tb/tb_rle_stream_decompress.sv - scoreboard bench for rle_stream_decompress
module tb_rle_stream_decompress;

    localparam int OUT_W = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_zero_run = '0;
    logic [7:0]       in_one_run = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] out_data;
    logic [8:0]       out_fill;
    logic             out_last;
    logic [31:0]      bit_count;
    logic [28:0]      byte_indx;
    logic [2:0]       bit_indx;
    logic             busy;

    rle_stream_decompress dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_zero_run(in_zero_run), .in_one_run(in_one_run), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_fill(out_fill), .out_last(out_last),
        .bit_count(bit_count), .byte_indx(byte_indx), .bit_indx(bit_indx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               fill;
        bit               last;
    } word_t;

    word_t            exp_q[$];
    logic [OUT_W-1:0] m_word;
    int               m_fill;
    int               m_bits;
    int               pass_cnt = 0;
    int               total_cnt = 0;

    logic [OUT_W-1:0] obs_data [256];
    logic [8:0]       obs_fill [256];
    logic             obs_last [256];
    int               obs_wr = 0;
    int               obs_rd = 0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_data[obs_wr % 256] <= out_data;
            obs_fill[obs_wr % 256] <= out_fill;
            obs_last[obs_wr % 256] <= out_last;
            obs_wr <= obs_wr + 1;
        end
    end

    task automatic model_token(input int z, input int o, input bit l);
        bit    ended_last = 1'b0;
        word_t w;
        for (int i = 0; i < z + o; i++) begin
            m_word[OUT_W-1-m_fill] = (i >= z);
            m_fill++;
            m_bits++;
            ended_last = 1'b0;
            if (m_fill == OUT_W) begin
                w.data = m_word; w.fill = OUT_W; w.last = l && (i == z + o - 1);
                exp_q.push_back(w);
                ended_last = w.last;
                m_word = '0; m_fill = 0;
            end
        end
        if (l && !ended_last) begin
            w.data = m_word; w.fill = m_fill; w.last = 1'b1;
            exp_q.push_back(w);
            m_word = '0; m_fill = 0;
        end
    endtask

    task automatic send_token(input int z, input int o, input bit l);
        bit ok = 1'b0;
        model_token(z, o, l);
        in_zero_run = 8'(z); in_one_run = 8'(o); in_last = l; in_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            total_cnt++;
            $display("FAIL send_token: in_ready stuck at %0b, required 1", in_ready);
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !out_valid && (obs_wr - obs_rd) >= exp_q.size()) ok = 1'b1;
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL %s drain timeout: busy=%0b words=%0d required idle with %0d words",
                     name, busy, obs_wr - obs_rd, exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_word = '0; m_fill = 0; m_bits = 0;
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b busy=%0b out_last=%0b required 1 0 0 0",
                     in_ready, out_valid, busy, out_last);
        end else pass_cnt++;
        total_cnt++;
        if (bit_count !== 32'd0 || out_fill !== 9'd0 || out_data !== '0) begin
            $display("FAIL reset_data: bit_count=%0d out_fill=%0d out_data=%h required 0 0 0",
                     bit_count, out_fill, out_data);
        end else pass_cnt++;
    endtask

    task automatic test_mixed_flush();
        word_t w;
        do_reset();
        send_token(3, 8, 1'b0);
        send_token(15, 9, 1'b0);
        send_token(8, 17, 1'b1);
        wait_drain("mixed_flush");
        total_cnt++;
        if (bit_count !== 32'd60 || byte_indx !== 29'd7 || bit_indx !== 3'd4) begin
            $display("FAIL mixed_count: bit_count=%0d byte=%0d bit=%0d required 60 7 4",
                     bit_count, byte_indx, bit_indx);
        end else pass_cnt++;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            total_cnt++;
            if (obs_rd == obs_wr) $display("FAIL mixed_word missing: got none, required fill=%0d", w.fill);
            else begin
                if (obs_data[obs_rd%256] !== w.data || obs_fill[obs_rd%256] !== 9'(w.fill) || obs_last[obs_rd%256] !== w.last)
                    $display("FAIL mixed_word: fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                             obs_fill[obs_rd%256], obs_last[obs_rd%256], obs_data[obs_rd%256], w.fill, w.last, w.data);
                else pass_cnt++;
                obs_rd++;
            end
        end
        total_cnt++;
        if (obs_rd != obs_wr) $display("FAIL mixed_extra: extra words=%0d required 0", obs_wr - obs_rd);
        else pass_cnt++;
    endtask

    task automatic test_throughput();
        word_t w;
        int    cyc = 0;
        bit    busy_low = 1'b0;
        do_reset();
        send_token(0, 200, 1'b1);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (!busy) busy_low = 1'b1;
        end
        total_cnt++;
        if (cyc !== 25 || busy_low) $display("FAIL throughput: cycles=%0d busy_dropped=%0b required 25 0", cyc, busy_low);
        else pass_cnt++;
        total_cnt++;
        if (bit_count !== 32'd200 || byte_indx !== 29'd25 || bit_indx !== 3'd0)
            $display("FAIL throughput_count: bit_count=%0d byte=%0d required 200 25", bit_count, byte_indx);
        else pass_cnt++;
        wait_drain("throughput");
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            total_cnt++;
            if (obs_rd == obs_wr) $display("FAIL throughput_word missing: got none, required fill=%0d", w.fill);
            else begin
                if (obs_data[obs_rd%256] !== w.data || obs_fill[obs_rd%256] !== 9'(w.fill) || obs_last[obs_rd%256] !== w.last)
                    $display("FAIL throughput_word: fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                             obs_fill[obs_rd%256], obs_last[obs_rd%256], obs_data[obs_rd%256], w.fill, w.last, w.data);
                else pass_cnt++;
                obs_rd++;
            end
        end
    endtask

    task automatic test_word_boundary();
        word_t w;
        do_reset();
        send_token(0, 255, 1'b0);
        send_token(0, 1, 1'b0);
        send_token(0, 5, 1'b1);
        wait_drain("boundary");
        total_cnt++;
        if (exp_q.size() != 2 || exp_q[0].fill != 256 || exp_q[0].last || exp_q[1].fill != 5)
            $display("FAIL boundary_model: words=%0d required 2 with fills 256 and 5", exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            total_cnt++;
            if (obs_rd == obs_wr) $display("FAIL boundary_word missing: got none, required fill=%0d", w.fill);
            else begin
                if (obs_data[obs_rd%256] !== w.data || obs_fill[obs_rd%256] !== 9'(w.fill) || obs_last[obs_rd%256] !== w.last)
                    $display("FAIL boundary_word: fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                             obs_fill[obs_rd%256], obs_last[obs_rd%256], obs_data[obs_rd%256], w.fill, w.last, w.data);
                else pass_cnt++;
                obs_rd++;
            end
        end
        total_cnt++;
        if (bit_count !== 32'd261) $display("FAIL boundary_count: bit_count=%0d required 261", bit_count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        word_t            w;
        logic [OUT_W-1:0] d0;
        logic [8:0]       f0;
        bit               seen = 1'b0;
        bit               moved = 1'b0;
        do_reset();
        out_ready = 1'b0;
        send_token(100, 200, 1'b1);
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        d0 = out_data; f0 = out_fill;
        total_cnt++;
        if (!seen || f0 !== 9'd256 || bit_count !== 32'd256)
            $display("FAIL bp_emit: seen=%0b fill=%0d bit_count=%0d required 1 256 256", seen, f0, bit_count);
        else pass_cnt++;
        repeat (10) begin
            @(negedge clk);
            if (out_data !== d0 || out_fill !== f0 || in_ready !== 1'b0 || bit_count !== 32'd256 || !out_valid)
                moved = 1'b1;
        end
        total_cnt++;
        if (moved) $display("FAIL bp_hold: fill=%0d in_ready=%0b bit_count=%0d required 256 0 256",
                            out_fill, in_ready, bit_count);
        else pass_cnt++;
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain("backpressure");
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            total_cnt++;
            if (obs_rd == obs_wr) $display("FAIL bp_word missing: got none, required fill=%0d", w.fill);
            else begin
                if (obs_data[obs_rd%256] !== w.data || obs_fill[obs_rd%256] !== 9'(w.fill) || obs_last[obs_rd%256] !== w.last)
                    $display("FAIL bp_word: fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                             obs_fill[obs_rd%256], obs_last[obs_rd%256], obs_data[obs_rd%256], w.fill, w.last, w.data);
                else pass_cnt++;
                obs_rd++;
            end
        end
        total_cnt++;
        if (bit_count !== 32'd300) $display("FAIL bp_count: bit_count=%0d required 300", bit_count);
        else pass_cnt++;
    endtask

    task automatic test_empty_tokens();
        word_t w;
        bit    spurious = 1'b0;
        do_reset();
        send_token(0, 0, 1'b1);
        wait_drain("empty_last");
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            total_cnt++;
            if (obs_rd == obs_wr) $display("FAIL empty_word missing: got none, required fill=%0d", w.fill);
            else begin
                if (obs_data[obs_rd%256] !== w.data || obs_fill[obs_rd%256] !== 9'(w.fill) || obs_last[obs_rd%256] !== w.last)
                    $display("FAIL empty_word: fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                             obs_fill[obs_rd%256], obs_last[obs_rd%256], obs_data[obs_rd%256], w.fill, w.last, w.data);
                else pass_cnt++;
                obs_rd++;
            end
        end
        send_token(0, 0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            if (out_valid || busy) spurious = 1'b1;
        end
        total_cnt++;
        if (spurious || in_ready !== 1'b1 || obs_rd != obs_wr || bit_count !== 32'd0)
            $display("FAIL empty_nolast: spurious=%0b in_ready=%0b words=%0d bit_count=%0d required 0 1 0 0",
                     spurious, in_ready, obs_wr - obs_rd, bit_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        word_t w;
        bit    hit = 1'b0;
        do_reset();
        send_token(4, 0, 1'b0);
        send_token(0, 200, 1'b0);
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (bit_count == 32'd100) hit = 1'b1;
        end
        rst = 1'b1;
        #1;
        total_cnt++;
        if (!hit || out_valid !== 1'b0 || busy !== 1'b0 || bit_count !== 32'd0 || out_fill !== 9'd0 || out_data !== '0)
            $display("FAIL midrun_reset: hit=%0b out_valid=%0b busy=%0b bit_count=%0d out_fill=%0d required 1 0 0 0 0",
                     hit, out_valid, busy, bit_count, out_fill);
        else pass_cnt++;
        do_reset();
        send_token(2, 2, 1'b1);
        wait_drain("midrun");
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            total_cnt++;
            if (obs_rd == obs_wr) $display("FAIL midrun_word missing: got none, required fill=%0d", w.fill);
            else begin
                if (obs_data[obs_rd%256] !== w.data || obs_fill[obs_rd%256] !== 9'(w.fill) || obs_last[obs_rd%256] !== w.last)
                    $display("FAIL midrun_word: fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                             obs_fill[obs_rd%256], obs_last[obs_rd%256], obs_data[obs_rd%256], w.fill, w.last, w.data);
                else pass_cnt++;
                obs_rd++;
            end
        end
    endtask

    task automatic test_back_to_back();
        word_t w;
        bit    tok_done = 1'b0;
        do_reset();
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send_token($urandom_range(0, 255), $urandom_range(0, 255),
                               (i == 29) || ($urandom_range(0, 7) == 0));
                tok_done = 1'b1;
            end
            begin
                while (!tok_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("back_to_back");
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            total_cnt++;
            if (obs_rd == obs_wr) $display("FAIL b2b_word missing: got none, required fill=%0d", w.fill);
            else begin
                if (obs_data[obs_rd%256] !== w.data || obs_fill[obs_rd%256] !== 9'(w.fill) || obs_last[obs_rd%256] !== w.last)
                    $display("FAIL b2b_word: fill=%0d last=%0b data=%h required fill=%0d last=%0b data=%h",
                             obs_fill[obs_rd%256], obs_last[obs_rd%256], obs_data[obs_rd%256], w.fill, w.last, w.data);
                else pass_cnt++;
                obs_rd++;
            end
        end
        total_cnt++;
        if (obs_rd != obs_wr || bit_count !== 32'(m_bits))
            $display("FAIL b2b_tail: extra words=%0d bit_count=%0d required 0 %0d", obs_wr - obs_rd, bit_count, m_bits);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mixed_flush();
        test_throughput();
        test_word_boundary();
        test_backpressure();
        test_empty_tokens();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rle_stream_decompress.md
Name: rle_stream_decompress

Overview:
Streaming, parametrised run-length bit decompressor. It accepts tokens of the form (zero-run, one-run) over a valid/ready handshake and expands each token MSB-first into an OUT_W-bit output buffer, at up to BITS_PER_CYC bits per clock. Full words go out over a second valid/ready handshake. A flagged last token flushes a zero-padded partial word. It sits between the compressed-stream reader and the feature-map buffer in the IO module.

Parameters:
OUT_W, 256, output word width in bits; must be a multiple of BITS_PER_CYC.
RUN_W, 8, width of each run-length field; a run is 0..2^RUN_W-1 bits.
BITS_PER_CYC, 8, maximum bits written per cycle; must be a power of two.
CNT_W, 32, width of the running bit counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  token valid.
in_ready  out  1  token accepted when in_valid && in_ready.
in_zero_run  in  RUN_W  number of 0 bits, emitted first.
in_one_run  in  RUN_W  number of 1 bits, emitted after the zeros.
in_last  in  1  marks the final token of a stream; forces a flush.
out_valid  out  1  output word valid.
out_ready  in  1  output word consumed when out_valid && out_ready.
out_data  out  OUT_W  expanded bits; first bit sits at OUT_W-1; unwritten bits are 0.
out_fill  out  $clog2(OUT_W)+1  number of valid bits in out_data.
out_last  out  1  word contains the final bit of the stream.
bit_count  out  CNT_W  total bits expanded since reset; wraps modulo 2^CNT_W.
byte_indx  out  CNT_W-3  bit_count>>3.
bit_indx  out  3  bit_count[2:0].
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE. buffer, fill, remaining-run counters, bit_count, out_valid, out_last and out_fill are all 0. in_ready=1 after reset deasserts. A partial word is discarded.
- States: IDLE, ZEROS, ONES, EMIT, FLUSH.
- IDLE: in_ready=1. On handshake, latch zero_rem, one_rem and last_f.
  - Next state is ZEROS if zero_rem>0.
  - Otherwise ONES if one_rem>0.
  - Otherwise FLUSH if last_f.
  - Otherwise stay in IDLE (empty token, no output).
- in_ready=0 in every state except IDLE. Expansion starts the cycle after acceptance.
- ZEROS and ONES, each cycle:
  - n = min(rem, BITS_PER_CYC, OUT_W-fill).
  - Write n bits of value 0 or 1 into buffer[OUT_W-1-fill -: n].
  - fill+=n, rem-=n, bit_count+=n.
- Transitions out of ZEROS/ONES:
  - If fill reaches OUT_W, go to EMIT. The resume state records where the token continues.
  - Otherwise, ZEROS moves to ONES when zero_rem hits 0 (or straight to the ONES-complete handling if one_rem=0).
  - Completing ONES goes to FLUSH if last_f, else IDLE.
- EMIT: out_valid=1, out_fill=OUT_W. out_last=1 only if the token is last_f and both runs are exhausted.
  - out_data, out_fill and out_last stay stable until out_ready.
  - On handshake: buffer=0, fill=0, then go to the resume state. If the resume state would be FLUSH on an exactly-full last word, go to IDLE instead: that word already carried out_last.
- FLUSH: out_valid=1, out_fill=fill (0 is legal), out_last=1. On handshake: clear buffer and fill, go to IDLE.
- Backpressure: while out_valid && !out_ready, no bits are written and bit_count holds.
- Throughput: one token of L total bits takes ceil(zero/BPC)+ceil(one/BPC) expansion cycles, plus EMIT/FLUSH cycles.
- A run that crosses a word boundary continues into the next word with no lost or duplicated bits.
- in_* are ignored outside the IDLE handshake.

Decomposition:
- Package rle_pkg: state enum, fill-width and run-width localparams, a min3 function.
- One combinational sub-module, rle_bit_writer (inputs buffer, fill, n, value; output next buffer), which builds the insert mask.
- The FSM, counters and handshakes stay in the top module.

Test Plan:
- Tokens (3,8), (15,9), (8,17,last), out_ready=1 → one FLUSH word: out_fill=60, out_last=1, out_data[255:245]=00011111111, next 24 bits=000000000000000111111111, next 25 bits=0000000011111111111111111, rest 0, bit_count=60.
- Token (0,200) → 25 expansion cycles after acceptance; busy high throughout; bit_count=200.
- Tokens (0,255), (0,1), (0,5,last) → first word all ones with out_fill=256, out_last=0; second word out_fill=5, top 5 bits 1, out_last=1.
- out_ready held 0 for 10 cycles during EMIT → out_data and out_fill stable, in_ready=0, bit_count unchanged; after release, expansion resumes with no bit loss.
- Token (0,0,last) with fill=0 → single word: out_fill=0, out_data=0, out_last=1. Token (0,0,no last) → no output, returns to IDLE.
- Assert rst mid-ONES with fill=100 → outputs immediately 0, state IDLE. The next stream (2,2,last) yields out_fill=4, out_data[255:252]=0011.
